// File: rtl/arb_txn_engine.sv
// Turns a one-hot arbiter grant into a single valid/ready transaction on a shared target port.
// Optional response timeout is compiled in with `define TXN_TIMEOUT_EN.
module arb_txn_engine #(
  parameter int unsigned N      = 4,
  parameter int unsigned DW     = 32,
  parameter int unsigned TO_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_an,
  input  logic [N-1:0]    grant,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            grant_err,
  output logic            tgt_valid,
  output logic [DW-1:0]   tgt_data,
  input  logic            tgt_ready,
  input  logic            tgt_rsp_valid,
  input  logic [DW-1:0]   tgt_rsp_data,
  input  logic            tgt_rsp_err
);

  if (TO_CYC < 2) begin : g_bad_to_cyc
    $error("arb_txn_engine: TO_CYC must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            grant_err_q, grant_err_d;
  logic            tgt_valid_q, tgt_valid_d;
  logic [DW-1:0]   tgt_data_q, tgt_data_d;
  logic [DW-1:0]   sel_data;
  logic            grant_onehot;
  logic            grant_multi;

`ifdef TXN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  assign grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
  assign grant_multi  = (grant != '0) && !grant_onehot;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) sel_data = req_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ack_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      grant_err_q <= 1'b0;
      tgt_valid_q <= 1'b0;
      tgt_data_q  <= '0;
`ifdef TXN_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ack_q       <= ack_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      grant_err_q <= grant_err_d;
      tgt_valid_q <= tgt_valid_d;
      tgt_data_q  <= tgt_data_d;
`ifdef TXN_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ack_d       = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    grant_err_d = grant_err_q;
    tgt_valid_d = tgt_valid_q;
    tgt_data_d  = tgt_data_q;
`ifdef TXN_TIMEOUT_EN
    timer_d     = timer_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_onehot) begin
          idx_d       = grant;
          tgt_data_d  = sel_data;
          tgt_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end else if (grant_multi) begin
          grant_err_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (tgt_valid_q && tgt_ready) begin
          tgt_valid_d = 1'b0;
          state_d     = S_WAIT;
`ifdef TXN_TIMEOUT_EN
          timer_d     = '0;
`endif
        end
      end
      S_WAIT: begin
`ifdef TXN_TIMEOUT_EN
        timer_d = timer_q + 1'b1;
`endif
        // A response arriving in the expiry cycle takes priority over the timeout.
        if (tgt_rsp_valid) begin
          rsp_data_d = tgt_rsp_data;
          rsp_err_d  = tgt_rsp_err;
          ack_d      = idx_q;
          state_d    = S_ACK;
        end
`ifdef TXN_TIMEOUT_EN
        else if (timer_d == TW'(TO_CYC)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          ack_d      = idx_q;
          state_d    = S_ACK;
        end
`endif
      end
      S_ACK: begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        state_d    = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack       = ack_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign grant_err = grant_err_q;
  assign tgt_valid = tgt_valid_q;
  assign tgt_data  = tgt_data_q;

endmodule
